// File: rtl/logic_op_if.sv
// Streaming bundle for logic_op_unit: input beat channel plus registered result channel.
// master drives operands and accepts results; slave is the logic unit itself.
interface logic_op_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_last, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_count, out_ovf
    );
endinterface

// File: rtl/logic_op_unit.sv
// Registered WIDTH-bit bitwise logic unit: six per-beat ops plus OR/AND burst reductions
// closed by in_last or force-closed after MAX_LEN beats.
module logic_op_unit #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    logic_op_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] acc, acc_next, beat_acc, start_acc;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic             locked_and, locked_and_next;
    logic             in_ready_w, accept;
    logic             emit, emit_ovf;
    logic [WIDTH-1:0] emit_data;
    logic [CNT_W-1:0] emit_count;
    logic             out_valid_r, out_zero_r, out_ovf_r;
    logic [WIDTH-1:0] out_data_r;
    logic [CNT_W-1:0] out_count_r;

    function automatic logic [WIDTH-1:0] beat_op(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a & b);
            3'd4:    r = ~(a | b);
            3'd5:    r = ~(a ^ b);
            default: r = '0;
        endcase
        return r;
    endfunction

    // A beat can only enter when the output register is free or being drained.
    assign in_ready_w = !out_valid_r || bus.out_ready;
    assign accept     = bus.in_valid && in_ready_w;

    always_comb begin
        state_next      = state;
        acc_next        = acc;
        cnt_next        = cnt;
        locked_and_next = locked_and;
        emit            = 1'b0;
        emit_data       = '0;
        emit_count      = '0;
        emit_ovf        = 1'b0;
        cnt_inc         = cnt + CNT_W'(1);
        start_acc       = bus.in_op[0] ? (bus.in_a & bus.in_b) : (bus.in_a | bus.in_b);
        beat_acc        = locked_and ? (acc & bus.in_a & bus.in_b) : (acc | bus.in_a | bus.in_b);

        if (accept) begin
            unique case (state)
                IDLE: begin
                    if (bus.in_op[2:1] != 2'b11) begin
                        emit       = 1'b1;
                        emit_data  = beat_op(bus.in_op, bus.in_a, bus.in_b);
                        emit_count = CNT_W'(1);
                    end else begin
                        locked_and_next = bus.in_op[0];
                        if (bus.in_last) begin
                            emit       = 1'b1;
                            emit_data  = start_acc;
                            emit_count = CNT_W'(1);
                        end else begin
                            state_next = ACCUM;
                            acc_next   = start_acc;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                end
                ACCUM: begin
                    // Burst closes on in_last, or is forced shut once it reaches MAX_LEN beats.
                    if (bus.in_last || cnt_inc == CNT_W'(MAX_LEN)) begin
                        emit       = 1'b1;
                        emit_data  = beat_acc;
                        emit_count = cnt_inc;
                        emit_ovf   = !bus.in_last;
                        state_next = IDLE;
                        acc_next   = '0;
                        cnt_next   = '0;
                    end else begin
                        acc_next = beat_acc;
                        cnt_next = cnt_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            locked_and <= 1'b0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            cnt        <= cnt_next;
            locked_and <= locked_and_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_zero_r  <= 1'b1;
            out_count_r <= '0;
            out_ovf_r   <= 1'b0;
        end else if (emit) begin
            out_valid_r <= 1'b1;
            out_data_r  <= emit_data;
            out_zero_r  <= (emit_data == '0);
            out_count_r <= emit_count;
            out_ovf_r   <= emit_ovf;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_zero  = out_zero_r;
    assign bus.out_count = out_count_r;
    assign bus.out_ovf   = out_ovf_r;
endmodule

// File: tb/tb_logic_op_unit.sv
// Self-checking bench for logic_op_unit: directed scenarios plus randomized streaming
// against a burst-list reference model.
module tb_logic_op_unit;
    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic clk;
    logic rst_n;

    logic_op_if #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) bus ();

    logic_op_unit #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic [CNT_W-1:0] exp_count;
    logic             exp_ovf;
    logic             exp_ready;
    logic             obs_ready;
    logic             accepted;
    logic             burst_active;
    logic             burst_and;
    logic [WIDTH-1:0] burst_q[$];

    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        exp_valid    = 1'b0;
        exp_data     = '0;
        exp_count    = '0;
        exp_ovf      = 1'b0;
        burst_active = 1'b0;
        burst_and    = 1'b0;
        burst_q.delete();
    endtask

    // A burst is remembered as the list of its per-beat terms and reduced only when it closes.
    task automatic model_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [2:0] op, input logic last, output logic emitted);
        logic [WIDTH-1:0] r;
        emitted = 1'b0;
        if (!burst_active && op < 3'd6) begin
            emitted   = 1'b1;
            exp_data  = ref_op(op, a, b);
            exp_count = CNT_W'(1);
            exp_ovf   = 1'b0;
        end else begin
            if (!burst_active) begin
                burst_active = 1'b1;
                burst_and    = (op == 3'd7);
                burst_q.delete();
            end
            burst_q.push_back(burst_and ? (a & b) : (a | b));
            if (last || burst_q.size() == MAX_LEN) begin
                r = burst_and ? '1 : '0;
                foreach (burst_q[i]) r = burst_and ? (r & burst_q[i]) : (r | burst_q[i]);
                emitted      = 1'b1;
                exp_data     = r;
                exp_count    = CNT_W'(burst_q.size());
                exp_ovf      = !last;
                burst_active = 1'b0;
            end
        end
        if (emitted) exp_valid = 1'b1;
    endtask

    // Drive one cycle starting at posedge+1; returns at the following posedge+1.
    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] op, input logic last, input logic rdy);
        logic emitted;
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_op     = op;
        bus.in_last   = last;
        bus.out_ready = rdy;
        #3;
        obs_ready = bus.in_ready;
        exp_ready = !exp_valid || rdy;
        accepted  = v && exp_ready;
        emitted   = 1'b0;
        if (accepted) model_beat(a, b, op, last, emitted);
        if (!emitted && rdy) exp_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.in_op = 3'd0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        model_reset();
        #12;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_zero !== 1'b1 ||
            bus.out_count !== 5'd0 || bus.out_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_values: got valid=%b data=%h zero=%b count=%0d ovf=%b, expected 0 00 1 0 0",
                     bus.out_valid, bus.out_data, bus.out_zero, bus.out_count, bus.out_ovf);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) drive(1'b1, 8'(1 << i), 8'h00, 3'd6, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_zero !== 1'b1 ||
            bus.out_count !== 5'd0 || bus.out_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_burst: got valid=%b data=%h zero=%b count=%0d ovf=%b, expected 0 00 1 0 0",
                     bus.out_valid, bus.out_data, bus.out_zero, bus.out_count, bus.out_ovf);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        drive(1'b1, 8'h0F, 8'hF0, 3'd1, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hFF || bus.out_count !== 5'd1 ||
            bus.out_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL or_after_reset: got valid=%b data=%h count=%0d ovf=%b, expected 1 ff 1 0",
                     bus.out_valid, bus.out_data, bus.out_count, bus.out_ovf);
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_truth_table();
        logic [7:0] tbl [6] = '{8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'hCC, 8'hAA, 3'(i), 1'b0, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== tbl[i] || bus.out_count !== 5'd1 ||
                bus.out_ovf !== 1'b0 || bus.out_zero !== 1'b0) begin
                failures++;
                $display("[TB] FAIL truth_op%0d: got valid=%b data=%h count=%0d ovf=%b, expected 1 %h 1 0",
                         i, bus.out_valid, bus.out_data, bus.out_count, bus.out_ovf, tbl[i]);
            end
            drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL truth_single_cycle%0d: got valid=%b, expected 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_acc_or();
        logic [2:0] ops [4] = '{3'd6, 3'd0, 3'd0, 3'd0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(1 << i), 8'h00, ops[i], (i == 3), 1'b1);
            if (i < 3) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL acc_or_no_partial%0d: got valid=%b, expected 0", i, bus.out_valid);
                end
            end
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h0F || bus.out_count !== 5'd4 ||
            bus.out_ovf !== 1'b0 || bus.out_zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL acc_or_result: got valid=%b data=%h count=%0d ovf=%b, expected 1 0f 4 0",
                     bus.out_valid, bus.out_data, bus.out_count, bus.out_ovf);
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_acc_and_ovf();
        int early = 0;
        for (int i = 0; i < MAX_LEN; i++) begin
            drive(1'b1, 8'hFF, 8'hFF, 3'd7, 1'b0, 1'b1);
            if (i < MAX_LEN - 1 && bus.out_valid !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("[TB] FAIL acc_and_no_partial: got %0d early outputs, expected 0", early);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hFF || bus.out_count !== 5'd16 ||
            bus.out_ovf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL acc_and_ovf: got valid=%b data=%h count=%0d ovf=%b, expected 1 ff 16 1",
                     bus.out_valid, bus.out_data, bus.out_count, bus.out_ovf);
        end
        drive(1'b1, 8'h3C, 8'hFF, 3'd7, 1'b1, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.out_count !== 5'd1 ||
            bus.out_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL acc_new_burst: got valid=%b data=%h count=%0d ovf=%b, expected 1 3c 1 0",
                     bus.out_valid, bus.out_data, bus.out_count, bus.out_ovf);
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] qa [6];
        logic [WIDTH-1:0] qb [6];
        logic [2:0]       qop [6];
        int idx = 0;
        int budget = 0;
        for (int i = 0; i < 6; i++) begin
            qa[i]  = 8'($urandom);
            qb[i]  = 8'($urandom);
            qop[i] = 3'($urandom_range(5, 0));
        end
        drive(1'b1, 8'h01, 8'h02, 3'd1, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, qa[idx], qb[idx], qop[idx], 1'b0, 1'b0);
            if (accepted) idx++;
            checks++;
            if (obs_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h03) begin
                failures++;
                $display("[TB] FAIL stall%0d: got ready=%b valid=%b data=%h, expected 0 1 03",
                         c, obs_ready, bus.out_valid, bus.out_data);
            end
        end
        while (idx < 6 && budget < 20) begin
            drive(1'b1, qa[idx], qb[idx], qop[idx], 1'b0, 1'b1);
            if (accepted) idx++;
            budget++;
            checks++;
            if (obs_ready !== exp_ready || bus.out_valid !== exp_valid ||
                (exp_valid && (bus.out_data !== exp_data || bus.out_zero !== (exp_data == '0) ||
                               bus.out_count !== exp_count || bus.out_ovf !== exp_ovf))) begin
                failures++;
                $display("[TB] FAIL resume: got ready=%b valid=%b data=%h count=%0d ovf=%b, expected ready=%b valid=%b data=%h count=%0d ovf=%b",
                         obs_ready, bus.out_valid, bus.out_data, bus.out_count, bus.out_ovf,
                         exp_ready, exp_valid, exp_data, exp_count, exp_ovf);
            end
        end
        checks++;
        if (idx != 6) begin
            failures++;
            $display("[TB] FAIL resume_budget: got %0d beats accepted, expected 6", idx);
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_zero_stream();
        drive(1'b1, 8'hF0, 8'h0F, 3'd0, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00 || bus.out_zero !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_flag: got valid=%b data=%h zero=%b, expected 1 00 1",
                     bus.out_valid, bus.out_data, bus.out_zero);
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(5, 0)), 1'b0, 1'b1);
            checks++;
            if (obs_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== exp_data ||
                bus.out_zero !== (exp_data == '0) || bus.out_count !== 5'd1 || bus.out_ovf !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stream%0d: got ready=%b valid=%b data=%h zero=%b count=%0d, expected ready=1 valid=1 data=%h count=1",
                         i, obs_ready, bus.out_valid, bus.out_data, bus.out_zero, bus.out_count, exp_data);
            end
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_random_mix();
        logic v, rdy, last;
        for (int i = 0; i < 300; i++) begin
            v    = ($urandom_range(3, 0) != 0);
            rdy  = ($urandom_range(9, 0) < 7);
            last = ($urandom_range(3, 0) == 0);
            drive(v, 8'($urandom), 8'($urandom), 3'($urandom_range(7, 0)), last, rdy);
            checks++;
            if (obs_ready !== exp_ready || bus.out_valid !== exp_valid ||
                (exp_valid && (bus.out_data !== exp_data || bus.out_zero !== (exp_data == '0) ||
                               bus.out_count !== exp_count || bus.out_ovf !== exp_ovf))) begin
                failures++;
                $display("[TB] FAIL random%0d: got ready=%b valid=%b data=%h zero=%b count=%0d ovf=%b, expected ready=%b valid=%b data=%h count=%0d ovf=%b",
                         i, obs_ready, bus.out_valid, bus.out_data, bus.out_zero, bus.out_count, bus.out_ovf,
                         exp_ready, exp_valid, exp_data, exp_count, exp_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_acc_or();
        test_acc_and_ovf();
        test_backpressure();
        test_zero_stream();
        test_random_mix();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
